// File: rtl/debounce_multi.sv
// Multi-channel counter-based push-button debouncer.
// Per channel: 2-flop sync, stability window, press/release/long-press strobes.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 1000,
    parameter int LONG_CYCLES   = 500000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic            any_pressed
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } state_e;

    localparam logic [N_CH-1:0]  IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LNG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic             LONG_EN  = (LONG_CYCLES != 0);

    logic [N_CH-1:0]  ff1_q, ff2_q, s;
    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  long_done_q, long_done_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  rel_q, rel_d;
    logic [N_CH-1:0]  long_q, long_d;

    // s=1 means pressed regardless of board polarity
    assign s = ff2_q ^ IDLE_RAW;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            long_done_d[i] = long_done_q[i];
            press_d[i]     = 1'b0;
            rel_d[i]       = 1'b0;
            long_d[i]      = 1'b0;
            unique case (state_q[i])
                IDLE: begin
                    if (s[i]) begin
                        state_d[i] = PRESS_CHECK;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CHECK: begin
                    if (!s[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == STB_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASE_CHECK;
                        cnt_d[i]   = '0;
                    end else begin
                        if (cnt_q[i] != LNG_MAX) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                        if (LONG_EN && !long_done_q[i] &&
                            cnt_q[i] == LNG_LAST) begin
                            long_d[i]      = 1'b1;
                            long_done_d[i] = 1'b1;
                        end
                    end
                end
                RELEASE_CHECK: begin
                    // long_done kept so one press yields one long strobe
                    if (s[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == STB_LAST) begin
                        state_d[i]     = IDLE;
                        cnt_d[i]       = '0;
                        long_done_d[i] = 1'b0;
                        rel_d[i]       = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q       <= IDLE_RAW;
            ff2_q       <= IDLE_RAW;
            long_done_q <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            long_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            ff1_q       <= btn;
            ff2_q       <= ff1_q;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            level[i] = (state_q[i] == PRESSED) ||
                       (state_q[i] == RELEASE_CHECK);
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign any_pressed   = |level;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: expected strobes queued by stimulus,
// popped and compared by a monitor whenever any strobe is seen.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'hF;
    logic [3:0] level, press_pulse, release_pulse, long_pulse;
    logic       any_pressed;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int e0;

    typedef struct {
        int       cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic [3:0] lv;
    } exp_t;

    exp_t q[$];

    debounce_multi #(
        .N_CH(4),
        .CNT_W(8),
        .STABLE_CYCLES(4),
        .LONG_CYCLES(10),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push(input int c, input logic [3:0] pr,
                        input logic [3:0] rl, input logic [3:0] lg,
                        input logic [3:0] lv);
        exp_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        e.lv  = lv;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, req, edge_cnt);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (|{press_pulse, release_pulse, long_pulse}) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: edge %0d pr=%h rl=%h lg=%h",
                         edge_cnt, press_pulse, release_pulse, long_pulse);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != edge_cnt || e.pr !== press_pulse ||
                    e.rl !== release_pulse || e.lg !== long_pulse ||
                    e.lv !== level || (|e.lv) !== any_pressed) begin
                    errors++;
                    $display("FAIL pulse_event: got edge %0d pr=%h rl=%h lg=%h lv=%h any=%b expected edge %0d pr=%h rl=%h lg=%h lv=%h",
                             edge_cnt, press_pulse, release_pulse,
                             long_pulse, level, any_pressed, e.cyc,
                             e.pr, e.rl, e.lg, e.lv);
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset_async_outputs",
            {level, press_pulse, release_pulse, long_pulse, 3'b0, any_pressed},
            32'h0);
        wait_n(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_n(1);
            chk("post_reset_idle",
                {level, press_pulse, release_pulse, long_pulse, 3'b0, any_pressed},
                32'h0);
        end

        // clean press / release on channel 0
        btn[0] = 1'b0;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h1, 4'h0, 4'h0, 4'h1);
        wait_n(6);
        chk("ch0_level_before_accept", {28'h0, level}, 32'h0);
        wait_n(2);
        chk("ch0_level_held", {28'h0, level}, 32'h1);
        btn[0] = 1'b1;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h0, 4'h1, 4'h0, 4'h0);
        wait_n(10);
        chk("ch0_level_released", {28'h0, level}, 32'h0);

        // bounce on channel 1 never qualifies
        for (int i = 0; i < 40; i++) begin
            btn[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            wait_n(1);
            chk("ch1_bounce_level", {31'h0, level[1]}, 32'h0);
        end
        btn[1] = 1'b1;
        wait_n(8);
        chk("ch1_settled_level", {28'h0, level}, 32'h0);

        // long press on channel 2
        btn[2] = 1'b0;
        e0 = edge_cnt + 1;
        push(e0 + 6,  4'h4, 4'h0, 4'h0, 4'h4);
        push(e0 + 16, 4'h0, 4'h0, 4'h4, 4'h4);
        wait_n(30);
        btn[2] = 1'b1;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h0, 4'h4, 4'h0, 4'h0);
        wait_n(10);

        // release glitch on channel 3 after long strobe
        btn[3] = 1'b0;
        e0 = edge_cnt + 1;
        push(e0 + 6,  4'h8, 4'h0, 4'h0, 4'h8);
        push(e0 + 16, 4'h0, 4'h0, 4'h8, 4'h8);
        wait_n(20);
        btn[3] = 1'b1;
        wait_n(2);
        btn[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_n(1);
            chk("ch3_glitch_level", {31'h0, level[3]}, 32'h1);
        end
        btn[3] = 1'b1;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h0, 4'h8, 4'h0, 4'h0);
        wait_n(10);

        // all channels together
        btn = 4'h0;
        e0 = edge_cnt + 1;
        push(e0 + 6,  4'hF, 4'h0, 4'h0, 4'hF);
        push(e0 + 16, 4'h0, 4'h0, 4'hF, 4'hF);
        wait_n(20);
        chk("all_any_pressed", {31'h0, any_pressed}, 32'h1);
        btn = 4'hF;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h0, 4'hF, 4'h0, 4'h0);
        wait_n(10);
        chk("all_released_any", {31'h0, any_pressed}, 32'h0);

        // reset abort mid PRESS_CHECK, then restart from IDLE
        btn[0] = 1'b0;
        wait_n(4);
        rst = 1'b1;
        #1;
        chk("abort_reset_outputs",
            {level, press_pulse, release_pulse, long_pulse, 3'b0, any_pressed},
            32'h0);
        wait_n(3);
        rst = 1'b0;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h1, 4'h0, 4'h0, 4'h1);
        wait_n(5);
        chk("restart_level_pending", {28'h0, level}, 32'h0);
        wait_n(3);
        btn[0] = 1'b1;
        e0 = edge_cnt + 1;
        push(e0 + 6, 4'h0, 4'h1, 4'h0, 4'h0);
        wait_n(12);

        chk("queue_drained", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
